// File: rtl/rgb2gray_writer_if.sv
// Pixel-in / gray-BRAM-out bus of the RGB-to-gray writer, plus the frame
// handoff pair shared with the Sobel stage.
interface rgb2gray_writer_if #(
  parameter int ADDR_W = 17
);
  logic              i_PIX_VALID;
  logic              i_SOF;
  logic [7:0]        i_R;
  logic [7:0]        i_G;
  logic [7:0]        i_B;
  logic              o_READY;
  logic [ADDR_W-1:0] o_ADDRESS_2GRAYBRAM;
  logic              o_WRITE_GRAYBRAM;
  logic [7:0]        o_DATA_2GRAYBRAM;
  logic              START_RDGRAYBRAM;
  logic              DONE_CAL;

  modport master (
    output i_PIX_VALID, i_SOF, i_R, i_G, i_B, DONE_CAL,
    input  o_READY, o_ADDRESS_2GRAYBRAM, o_WRITE_GRAYBRAM, o_DATA_2GRAYBRAM,
           START_RDGRAYBRAM
  );

  modport slave (
    input  i_PIX_VALID, i_SOF, i_R, i_G, i_B, DONE_CAL,
    output o_READY, o_ADDRESS_2GRAYBRAM, o_WRITE_GRAYBRAM, o_DATA_2GRAYBRAM,
           START_RDGRAYBRAM
  );
endinterface

// File: rtl/rgb2gray_writer.sv
// Converts a raster RGB stream to 8-bit luminance, writes one frame into the
// gray BRAM at sequential addresses, then hands the frame to the Sobel stage.
module rgb2gray_writer #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17,
  parameter int KR     = 77,
  parameter int KG     = 150,
  parameter int KB     = 29
) (
  input  logic             i_CLK,
  input  logic             i_RSTn,
  rgb2gray_writer_if.slave bus
);
  localparam int                FRAME  = IMG_W * IMG_H;
  localparam int                STAGES = 2;
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(FRAME - 1);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
  localparam logic [7:0]        KR8    = 8'(KR);
  localparam logic [7:0]        KG8    = 8'(KG);
  localparam logic [7:0]        KB8    = 8'(KB);

  typedef enum logic [1:0] {FILL, DRAIN, HANDOFF} state_t;

  state_t            state, state_nx;
  logic              ready, ready_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic [ADDR_W-1:0] pix_addr;
  logic              accept;

  logic [STAGES:0]   vld_pipe;
  logic [7:0]        r0, g0, b0;
  logic [ADDR_W-1:0] addr0, addr1, addr2;
  logic [15:0]       pr, pg, pb;
  logic [7:0]        gray2;

  assign accept   = bus.i_PIX_VALID & ready;
  // SOF re-anchors the frame: this pixel lands at 0 regardless of the count
  assign pix_addr = bus.i_SOF ? '0 : cnt;

  always_comb begin
    state_nx = state;
    ready_nx = ready;
    cnt_nx   = cnt;
    unique case (state)
      FILL: begin
        ready_nx = 1'b1;
        if (accept) begin
          cnt_nx = pix_addr + ONE;
          if (pix_addr == LAST) begin
            cnt_nx   = '0;
            ready_nx = 1'b0;
            state_nx = DRAIN;
          end
        end
      end
      DRAIN: begin
        ready_nx = 1'b0;
        // no accepts here, so the last-address strobe is the frame's final write
        if (vld_pipe[STAGES] && addr2 == LAST) state_nx = HANDOFF;
      end
      HANDOFF: begin
        ready_nx = 1'b0;
        if (bus.DONE_CAL) begin
          ready_nx = 1'b1;
          cnt_nx   = '0;
          state_nx = FILL;
        end
      end
      default: begin
        ready_nx = 1'b0;
        cnt_nx   = '0;
        state_nx = FILL;
      end
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state <= FILL;
      ready <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      ready <= ready_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) vld_pipe <= '0;
    else         vld_pipe <= {vld_pipe[STAGES-1:0], accept};
  end

  // Stage 0: capture the accepted pixel with its address
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r0    <= '0;
      g0    <= '0;
      b0    <= '0;
      addr0 <= '0;
    end else if (accept) begin
      r0    <= bus.i_R;
      g0    <= bus.i_G;
      b0    <= bus.i_B;
      addr0 <= pix_addr;
    end
  end

  // Stage 1: weighted products
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      pr    <= '0;
      pg    <= '0;
      pb    <= '0;
      addr1 <= '0;
    end else if (vld_pipe[0]) begin
      pr    <= {8'd0, KR8} * {8'd0, r0};
      pg    <= {8'd0, KG8} * {8'd0, g0};
      pb    <= {8'd0, KB8} * {8'd0, b0};
      addr1 <= addr0;
    end
  end

  // Stage 2: rounded sum; weights total 256 so the result never exceeds 255
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      gray2 <= '0;
      addr2 <= '0;
    end else if (vld_pipe[1]) begin
      gray2 <= 8'(({1'b0, pr} + {1'b0, pg} + {1'b0, pb} + 17'd128) >> 8);
      addr2 <= addr1;
    end
  end

  assign bus.o_READY             = ready;
  assign bus.o_WRITE_GRAYBRAM    = vld_pipe[STAGES];
  assign bus.o_ADDRESS_2GRAYBRAM = addr2;
  assign bus.o_DATA_2GRAYBRAM    = gray2;
  assign bus.START_RDGRAYBRAM    = (state == HANDOFF);
endmodule
